// File: rtl/seven_seg_scan_driver_if.sv
// Host-side bus of the 7-segment scan driver.
//   enable     : scan runs when 1, display dark and scan frozen when 0
//   load       : 1-cycle strobe capturing digits_in / sign
//   digits_in  : nibble k is digit k (k=0 rightmost)
//   sign       : 1 = negative value
//   C          : active-low segments, C[7:1] = {g,f,e,d,c,b,a}
//   AN         : active-low anodes, AN[k] drives digit k
//   frame_done : 1-cycle pulse after each full scan frame
// master = data source / board side, slave = the driver itself.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    sign;
  logic [7:1]              C;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    frame_done;

  modport master (
    output enable, load, digits_in, sign,
    input  C, AN, frame_done
  );

  modport slave (
    input  enable, load, digits_in, sign,
    output C, AN, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Self-timed, time-multiplexed driver for an N-digit common-anode 7-segment
// display. Owns its refresh prescaler and digit scan, shows an optional sign
// slot in the MS position, blanks leading zero digits and only swaps in new
// data at frame boundaries so a frame never mixes old and new values.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : seven_seg_scan_driver_if.slave (enable/load/digits_in/sign in,
//           C/AN/frame_done out)

// Per-digit hex decoder lane: nibble -> active-low {g,f,e,d,c,b,a}.
module seven_seg_scan_driver_lane (
  input  logic [3:0] nibble,
  output logic [7:1] seg
);
  always_comb begin
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int SIGN_EN     = 1,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  // Highest digit that carries a value (the sign slot sits above it).
  localparam int TOP_VAL = (SIGN_EN != 0) ? NUM_DIGITS - 2 : NUM_DIGITS - 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MS   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:1]       SEG_OFF  = 7'h7F;
  localparam logic [7:1]       SEG_MINUS = 7'b0111111;

  typedef struct packed {
    logic                       sign;
    logic [NUM_DIGITS-1:0][3:0] digits;
  } disp_data_t;

  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;
  disp_data_t                  shadow, active, in_data;
  logic                        pending;
  logic                        tick, boundary;
  logic [NUM_DIGITS-1:0]       lz;
  logic                        above_zero;
  logic [NUM_DIGITS-1:0][7:1]  lane_seg;
  logic [7:1]                  seg_nxt;
  logic [NUM_DIGITS-1:0]       an_nxt;

  assign in_data.sign   = bus.sign;
  assign in_data.digits = bus.digits_in;

  assign tick     = bus.enable && (cnt == CNT_LAST);
  assign boundary = tick && (idx == '0);

  // One decoder per digit; the scan just selects a lane.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    seven_seg_scan_driver_lane u_lane (
      .nibble (active.digits[k]),
      .seg    (lane_seg[k])
    );
  end

  // Leading-zero flags, walked from the top value digit downwards: a digit is
  // blank while every value digit from it upward is zero. Digit 0 never blanks.
  always_comb begin
    lz         = '0;
    above_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (k <= TOP_VAL) begin
        above_zero = above_zero && (active.digits[k] == 4'h0);
        lz[k]      = (LZ_BLANK != 0) && above_zero;
      end
    end
  end

  // Pattern for the slot currently selected by idx.
  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = '1;
    if ((SIGN_EN != 0) && (idx == IDX_MS)) begin
      if (active.sign) begin
        seg_nxt = SEG_MINUS;
        an_nxt  = ~(NUM_DIGITS'(1) << idx);
      end
    end else if (!lz[idx]) begin
      seg_nxt = lane_seg[idx];
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= IDX_MS;
      shadow         <= '0;
      active         <= '0;
      pending        <= 1'b0;
      bus.C          <= SEG_OFF;
      bus.AN         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.enable) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)       idx <= (idx == '0) ? IDX_MS : idx - 1'b1;

      if (bus.load) shadow <= in_data;

      // A load landing on the boundary goes straight to the display so it is
      // not held back a whole extra frame.
      if (boundary && bus.load) begin
        active  <= in_data;
        pending <= 1'b0;
      end else if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      bus.frame_done <= boundary;
      bus.C          <= bus.enable ? seg_nxt : SEG_OFF;
      bus.AN         <= bus.enable ? an_nxt  : '1;
    end
  end
endmodule
